// File: rtl/irq_priority_core.sv
// rtl/irq_priority_core.sv - fully nested interrupt priority core with IRR/ISR,
// edge/level sensing, masking and optional rotating priority on end-of-interrupt.
module irq_priority_core #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensitivityMode,
  input  logic               rotateMode,
  input  logic [NUM_IRQ-1:0] peripheralInterrupts,
  input  logic [NUM_IRQ-1:0] interruptMask,
  input  logic               intAck,
  input  logic               eoi,
  output logic [NUM_IRQ-1:0] interruptRequest,
  output logic [NUM_IRQ-1:0] inService,
  output logic               intReq,
  output logic [IDX_W-1:0]   vectorIndex,
  output logic               vectorValid
);

  logic [NUM_IRQ-1:0] prev_sample_q, prev_sample_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ack_hold_q, ack_hold_d;
  logic [IDX_W-1:0]   lowest_ptr_q, lowest_ptr_d;
  logic [IDX_W-1:0]   vector_index_q, vector_index_d;
  logic               vector_valid_q, vector_valid_d;

  logic [NUM_IRQ-1:0] active;
  logic               cand_found, isr_found;
  logic [IDX_W-1:0]   cand_idx, cand_rank, isr_idx, isr_rank;
  logic               int_req;
  logic               ack;
  logic [NUM_IRQ-1:0] ack_vec, eoi_vec, set_vec;

  assign active = irr_q & ~interruptMask;

  // Walk the ring starting just above lowest_ptr; rank 0 is the highest priority.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_rank  = '0;
    isr_found  = 1'b0;
    isr_idx    = '0;
    isr_rank   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      int p;
      p = int'(lowest_ptr_q) + 1 + k;
      if (p >= NUM_IRQ) p = p - NUM_IRQ;
      if (!cand_found && active[p]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(p);
        cand_rank  = IDX_W'(k);
      end
      if (!isr_found && isr_q[p]) begin
        isr_found = 1'b1;
        isr_idx   = IDX_W'(p);
        isr_rank  = IDX_W'(k);
      end
    end
  end

  assign int_req = cand_found && (!isr_found || (cand_rank < isr_rank));
  assign ack     = intAck && int_req;

  always_comb begin
    ack_vec = '0;
    eoi_vec = '0;
    if (ack) ack_vec[cand_idx] = 1'b1;
    if (eoi && isr_found) eoi_vec[isr_idx] = 1'b1;
  end

  always_comb begin
    prev_sample_d  = peripheralInterrupts;
    // A level channel stays blocked after acknowledge until its input is seen low.
    ack_hold_d     = peripheralInterrupts & (ack_hold_q | ack_vec);
    set_vec        = sensitivityMode ? (peripheralInterrupts & ~ack_hold_d)
                                     : (peripheralInterrupts & ~prev_sample_q);
    irr_d          = sensitivityMode ? set_vec : ((irr_q & ~ack_vec) | set_vec);
    isr_d          = (isr_q & ~eoi_vec) | ack_vec;
    lowest_ptr_d   = lowest_ptr_q;
    vector_index_d = vector_index_q;
    vector_valid_d = intAck;
    if (eoi && isr_found && rotateMode) lowest_ptr_d = isr_idx;
    if (intAck) vector_index_d = int_req ? cand_idx : IDX_W'(NUM_IRQ - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sample_q  <= '0;
      irr_q          <= '0;
      isr_q          <= '0;
      ack_hold_q     <= '0;
      lowest_ptr_q   <= IDX_W'(NUM_IRQ - 1);
      vector_index_q <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      prev_sample_q  <= prev_sample_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      ack_hold_q     <= ack_hold_d;
      lowest_ptr_q   <= lowest_ptr_d;
      vector_index_q <= vector_index_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign interruptRequest = irr_q;
  assign inService        = isr_q;
  assign intReq           = int_req;
  assign vectorIndex      = vector_index_q;
  assign vectorValid      = vector_valid_q;

endmodule

// File: doc/irq_priority_core.md
IRQ_PRIORITY_CORE -- requirements
Module: irq_priority_core

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt channels; legal range 2..16.
REQ-002 SHALL have parameter IDX_W, default 3, channel-index width, equal to ceil(log2(NUM_IRQ)).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sensitivityMode  input  1  0 = edge-triggered, 1 = level-triggered; applies to all channels.
REQ-006 SHALL have port rotateMode  input  1  0 = fixed priority (channel 0 highest), 1 = automatic rotation on EOI.
REQ-007 SHALL have port peripheralInterrupts  input  NUM_IRQ  raw requests from peripherals.
REQ-008 SHALL have port interruptMask  input  NUM_IRQ  1 = channel masked.
REQ-009 SHALL have port intAck  input  1  one-cycle acknowledge pulse from CPU side.
REQ-010 SHALL have port eoi  input  1  one-cycle non-specific end-of-interrupt pulse.
REQ-011 SHALL have port interruptRequest  output  NUM_IRQ  registered IRR contents.
REQ-012 SHALL have port inService  output  NUM_IRQ  registered ISR contents.
REQ-013 SHALL have port intReq  output  1  interrupt request to CPU.
REQ-014 SHALL have port vectorIndex  output  IDX_W  channel granted by the last acknowledge.
REQ-015 SHALL have port vectorValid  output  1  one-cycle pulse qualifying vectorIndex.

Function
REQ-016 SHALL register peripheralInterrupts into prevSample each cycle, for edge detection.
REQ-017 Edge mode: IRR bit i SHALL set on the edge where peripheralInterrupts[i]=1 and prevSample[i]=0; it SHALL hold until acknowledged.
REQ-018 Level mode: IRR bit i SHALL set while peripheralInterrupts[i]=1 and SHALL clear on the edge where the input is 0 and the bit is not yet acknowledged.
REQ-019 Masked channels SHALL still latch into IRR but SHALL be excluded from arbitration.
REQ-020 Priority order SHALL run from (lowestPtr+1) mod NUM_IRQ (highest) around to lowestPtr (lowest); lowestPtr is a register.
REQ-021 Candidate SHALL be the highest-priority channel with IRR=1 and mask=0.
REQ-022 ISR-top SHALL be the highest-priority channel with ISR=1.
REQ-023 intReq SHALL be combinational from registers: 1 iff a candidate exists and either ISR is empty or the candidate outranks ISR-top (fully nested; equal or lower priority blocked).
REQ-024 On an intAck edge with intReq=1: IRR[candidate] SHALL clear, ISR[candidate] SHALL set, vectorIndex<=candidate, and vectorValid<=1 for exactly one cycle.
REQ-025 On an intAck edge with intReq=0 (spurious): vectorIndex<=NUM_IRQ-1, vectorValid<=1, with no IRR or ISR change.
REQ-026 On an eoi edge: the ISR-top bit SHALL clear; if rotateMode=1, lowestPtr<=that channel; eoi with ISR empty SHALL be a no-op.
REQ-027 When intAck and eoi occur in the same cycle, both SHALL be evaluated on the pre-edge state, and both updates SHALL apply.
REQ-028 When an acknowledge clear and a new edge or level set hit the same IRR bit in the same cycle, the set SHALL win.
REQ-029 The acknowledged-level bit SHALL not re-enter IRR until its input has been seen low at least once (per-channel ackHold flag, cleared when the input is low).
REQ-030 Mask changes SHALL take effect on intReq in the same cycle, with no state change.
REQ-031 Latency: edge at input, then IRR bit and intReq visible after 1 clock edge; intAck, then vectorValid after 1 edge.

Reset
REQ-032 On rst=1 the block SHALL asynchronously drive IRR, ISR, prevSample and ackHold to 0, lowestPtr to NUM_IRQ-1, and vectorIndex, vectorValid and intReq to 0.
REQ-033 Reset mid-operation SHALL discard pending and in-service state; an input held high through deassertion SHALL count as an edge in edge mode on the first sample after reset.

Verification (NUM_IRQ=8)
REQ-034 Edge mode, mask=0, pulse IR3 then IR5, intAck -> vectorIndex=3, ISR=0000_1000, IRR=0010_0000, intReq=0 (IR5 lower than ISR-top 3).
REQ-035 Nesting: ISR=0000_1000, IR1 rises -> intReq=1; intAck -> vectorIndex=1, ISR=0000_1010; eoi -> ISR=0000_1000.
REQ-036 Rotation: rotateMode=1, serve IR0 and eoi -> lowestPtr=0; IR0 and IR4 pending -> intAck gives vectorIndex=4.
REQ-037 Level mode: IR2 high 2 cycles then low before intAck -> IRR[2]=0, intReq=0; intAck -> spurious, vectorIndex=7, vectorValid=1.
REQ-038 Masking: IR6 pending with mask=0100_0000 -> intReq=0, IRR[6]=1; clear mask -> intReq=1 in the same cycle.
REQ-039 Simultaneous: ISR=0000_0100 with IR0 pending, intAck and eoi in one cycle -> ISR=0000_0001, vectorIndex=0; assert rst mid-sequence -> all outputs 0 immediately.
